// File: rtl/delete_loop_sched_if.sv
// Port bundle for delete_loop_sched: job request, loop-child handshake and status response.
// slave is the scheduler's view, master is the surrounding environment's view.
interface delete_loop_sched_if #(
  parameter int KEY_W = 32,
  parameter int CNT_W = 16
);
  logic             req_valid;
  logic             req_ready;
  logic [KEY_W-1:0] req_key;
  logic [CNT_W-1:0] req_len;

  logic             loop_ap_start;
  logic             loop_ap_ready;
  logic             loop_ap_done;
  logic             loop_iter_done;
  logic [KEY_W-1:0] loop_key;
  logic [CNT_W-1:0] loop_len;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [KEY_W-1:0] rsp_key;
  logic [CNT_W-1:0] rsp_iters;
  logic [1:0]       rsp_err;

  logic             idle;

  modport slave (
    input  req_valid, req_key, req_len,
    input  loop_ap_ready, loop_ap_done, loop_iter_done,
    input  rsp_ready,
    output req_ready,
    output loop_ap_start, loop_key, loop_len,
    output rsp_valid, rsp_key, rsp_iters, rsp_err,
    output idle
  );

  modport master (
    output req_valid, req_key, req_len,
    output loop_ap_ready, loop_ap_done, loop_iter_done,
    output rsp_ready,
    input  req_ready,
    input  loop_ap_start, loop_key, loop_len,
    input  rsp_valid, rsp_key, rsp_iters, rsp_err,
    input  idle
  );
endinterface

// File: rtl/delete_loop_sched.sv
// Launches the delete kernel's pipelined inner loop once per buffered job and
// reports iterations retired plus mismatch/timeout status per job.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for a job in the FIFO; pops head into loop args
// S_START | ap_start high until the child samples ap_ready
// S_RUN   | child running; count iterations and timeout until ap_done
// S_RESP  | status presented on rsp_*, held until rsp_ready
module delete_loop_sched #(
  parameter int KEY_W = 32,
  parameter int CNT_W = 16,
  parameter int DEPTH = 4,
  parameter int TMO_W = 12
) (
  input logic                 ap_clk,
  input logic                 ap_rst_n,
  delete_loop_sched_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_RUN   = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [KEY_W-1:0] r_fifo_key [DEPTH];
  logic [CNT_W-1:0] r_fifo_len [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             r_alive;

  logic [KEY_W-1:0] r_loop_key;
  logic [CNT_W-1:0] r_loop_len;
  logic [CNT_W-1:0] r_iter_cnt;
  logic [TMO_W-1:0] r_tmo_cnt;

  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic             w_rsp_hs;
  logic             w_tmo_hit;
  logic             w_counting;
  logic [KEY_W-1:0] w_head_key;
  logic [CNT_W-1:0] w_head_len;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign w_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_empty    = (r_wr_ptr == r_rd_ptr);
  assign w_push     = bus.req_valid && bus.req_ready;
  assign w_head_key = r_fifo_key[r_rd_ptr[AW-1:0]];
  assign w_head_len = r_fifo_len[r_rd_ptr[AW-1:0]];
  assign w_rsp_hs   = (r_state == S_RESP) && bus.rsp_ready;
  assign w_tmo_hit  = &r_tmo_cnt;
  assign w_counting = (r_state == S_START) || (r_state == S_RUN);

  always_ff @(posedge ap_clk) begin
    if (w_push) begin
      r_fifo_key[r_wr_ptr[AW-1:0]] <= bus.req_key;
      r_fifo_len[r_wr_ptr[AW-1:0]] <= bus.req_len;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_state    <= S_IDLE;
      r_alive    <= 1'b0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_loop_key <= '0;
      r_loop_len <= '0;
      r_iter_cnt <= '0;
      r_tmo_cnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_alive <= 1'b1;
      if (w_push) r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
      if (w_pop) begin
        r_rd_ptr   <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
        r_loop_key <= w_head_key;
        r_loop_len <= w_head_len;
      end
      if (w_rsp_hs) begin
        r_iter_cnt <= '0;
        r_tmo_cnt  <= '0;
      end else begin
        // Both counters saturate; the child is never aborted, only flagged.
        if (w_counting && bus.loop_iter_done && !(&r_iter_cnt))
          r_iter_cnt <= r_iter_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        if ((r_state == S_RUN) && !w_tmo_hit)
          r_tmo_cnt <= r_tmo_cnt + {{(TMO_W-1){1'b0}}, 1'b1};
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = (w_head_len == '0) ? S_RESP : S_START;
        end
      end
      S_START: begin
        if (bus.loop_ap_ready)
          w_state_nxt = bus.loop_ap_done ? S_RESP : S_RUN;
      end
      S_RUN: begin
        if (bus.loop_ap_done) w_state_nxt = S_RESP;
      end
      S_RESP: begin
        if (bus.rsp_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign bus.req_ready     = r_alive && !w_full;
  assign bus.loop_ap_start = (r_state == S_START);
  assign bus.loop_key      = r_loop_key;
  assign bus.loop_len      = r_loop_len;
  assign bus.rsp_valid     = (r_state == S_RESP);
  assign bus.rsp_key       = r_loop_key;
  assign bus.rsp_iters     = r_iter_cnt;
  assign bus.rsp_err       = (r_state == S_RESP) ?
                             {w_tmo_hit, (r_iter_cnt != r_loop_len)} : 2'b00;
  assign bus.idle          = (r_state == S_IDLE) && w_empty;

endmodule

// File: tb/tb_delete_loop_sched.sv
// Directed bench for delete_loop_sched: a behavioural loop child, a table of
// single-job vectors, and hand sequences for FIFO full, ordering, backpressure, timeout and reset.
module tb_delete_loop_sched;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  delete_loop_sched_if #(.KEY_W(32), .CNT_W(16)) bus ();

  delete_loop_sched #(.KEY_W(32), .CNT_W(16), .DEPTH(4), .TMO_W(12)) dut (
    .ap_clk   (clk),
    .ap_rst_n (rst_n),
    .bus      (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Child behaviour knobs, read at the start of each launch.
  int c_rdy_lat = 1;
  int c_iters   = 0;
  int c_extra   = 0;
  bit c_same    = 1'b0;
  bit c_hold    = 1'b0;
  bit c_chk     = 1'b1;
  bit c_busy    = 1'b0;

  initial begin
    bus.loop_ap_ready  = 1'b0;
    bus.loop_ap_done   = 1'b0;
    bus.loop_iter_done = 1'b0;
    forever begin
      step();
      if (rst_n && bus.loop_ap_start) begin
        c_busy = 1'b1;
        while (c_hold) step();
        if (c_same) begin
          for (int i = 0; i < c_iters - 1; i++) begin
            bus.loop_iter_done = 1'b1;
            step();
          end
          bus.loop_ap_ready  = 1'b1;
          bus.loop_ap_done   = 1'b1;
          bus.loop_iter_done = 1'b1;
          step();
          bus.loop_ap_ready  = 1'b0;
          bus.loop_ap_done   = 1'b0;
          bus.loop_iter_done = 1'b0;
        end else begin
          repeat (c_rdy_lat) step();
          bus.loop_ap_ready = 1'b1;
          step();
          bus.loop_ap_ready = 1'b0;
          if (c_chk) chk("start_drop", bus.loop_ap_start, 0);
          for (int i = 0; i < c_iters; i++) begin
            bus.loop_iter_done = 1'b1;
            step();
          end
          bus.loop_iter_done = 1'b0;
          repeat (c_extra) step();
          bus.loop_ap_done = 1'b1;
          step();
          bus.loop_ap_done = 1'b0;
        end
        if (c_chk) chk("rsp_after_done", bus.rsp_valid, 1);
        c_busy = 1'b0;
      end
    end
  end

  int          start_cnt = 0;
  logic [31:0] start_keys[$];
  logic        prev_start = 1'b0;
  initial begin
    forever begin
      step();
      if (bus.loop_ap_start && !prev_start) begin
        start_cnt++;
        start_keys.push_back(bus.loop_key);
      end
      prev_start = bus.loop_ap_start;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached with %0d checks, %0d errors", checks, errors);
    $fatal;
  end

  task automatic push(input logic [31:0] k, input logic [15:0] l);
    int n = 0;
    bus.req_valid = 1'b1;
    bus.req_key   = k;
    bus.req_len   = l;
    while (!bus.req_ready && n < 50) begin step(); n++; end
    chk("push_ready", bus.req_ready, 1);
    step();
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int budget);
    int n = 0;
    while (!bus.rsp_valid && n < budget) begin step(); n++; end
  endtask

  task automatic get_rsp(input string tag, input logic [31:0] k, input logic [15:0] it,
                         input logic [1:0] er, input int budget);
    wait_rsp(budget);
    chk({tag, "_valid"}, bus.rsp_valid, 1);
    if (bus.rsp_valid) begin
      chk({tag, "_key"},   bus.rsp_key,   k);
      chk({tag, "_iters"}, bus.rsp_iters, it);
      chk({tag, "_err"},   bus.rsp_err,   er);
      bus.rsp_ready = 1'b1;
      step();
      bus.rsp_ready = 1'b0;
    end
  endtask

  task automatic wait_child();
    int n = 0;
    while (c_busy && n < 200) begin step(); n++; end
    chk("child_quiet", c_busy, 0);
  endtask

  typedef struct {
    logic [31:0] key;
    logic [15:0] len;
    int          rdy;
    int          iters;
    bit          same;
    logic [15:0] e_iters;
    logic [1:0]  e_err;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int s0;
    vecs[0] = '{32'h0000_0010, 16'd5, 1, 5, 1'b0, 16'd5, 2'b00};
    vecs[1] = '{32'h0000_0020, 16'd6, 1, 4, 1'b0, 16'd4, 2'b01};
    vecs[2] = '{32'h0000_0030, 16'd0, 1, 0, 1'b0, 16'd0, 2'b00};
    vecs[3] = '{32'h0000_0040, 16'd3, 0, 3, 1'b1, 16'd3, 2'b00};
    vecs[4] = '{32'h0000_0050, 16'd2, 2, 7, 1'b0, 16'd7, 2'b01};
    vecs[5] = '{32'hDEAD_BEEF, 16'd1, 0, 1, 1'b0, 16'd1, 2'b00};

    bus.req_valid = 1'b0;
    bus.req_key   = '0;
    bus.req_len   = '0;
    bus.rsp_ready = 1'b0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", bus.req_ready,     0);
    chk("rst_start",     bus.loop_ap_start, 0);
    chk("rst_loop_key",  bus.loop_key,      0);
    chk("rst_loop_len",  bus.loop_len,      0);
    chk("rst_rsp_valid", bus.rsp_valid,     0);
    chk("rst_rsp_key",   bus.rsp_key,       0);
    chk("rst_rsp_iters", bus.rsp_iters,     0);
    chk("rst_rsp_err",   bus.rsp_err,       0);
    chk("rst_idle",      bus.idle,          1);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("rel_req_ready", bus.req_ready, 1);
    chk("rel_idle",      bus.idle,      1);

    // Single-job vectors
    for (int v = 0; v < 6; v++) begin
      c_rdy_lat = vecs[v].rdy;
      c_iters   = vecs[v].iters;
      c_same    = vecs[v].same;
      c_extra   = 0;
      s0        = start_cnt;
      push(vecs[v].key, vecs[v].len);
      chk("vec_busy",       bus.idle,          0);
      chk("vec_start_at_T", bus.loop_ap_start, 0);
      step();
      if (vecs[v].len != 0) begin
        chk("vec_start_T1", bus.loop_ap_start, 1);
        chk("vec_loop_key", bus.loop_key,      vecs[v].key);
        chk("vec_loop_len", bus.loop_len,      vecs[v].len);
      end else begin
        chk("vec_zero_rsp",   bus.rsp_valid,     1);
        chk("vec_zero_start", bus.loop_ap_start, 0);
      end
      get_rsp("vec", vecs[v].key, vecs[v].e_iters, vecs[v].e_err, 100);
      chk("vec_starts", start_cnt - s0, (vecs[v].len != 0) ? 1 : 0);
      wait_child();
      step();
      chk("vec_idle_end", bus.idle, 1);
    end
    c_same = 1'b0;

    // FIFO full while the child stalls
    c_rdy_lat = 1;
    c_iters   = 2;
    c_hold    = 1'b1;
    start_keys.delete();
    for (int i = 0; i < 5; i++) push(32'hA1 + i, 16'd2);
    step();
    step();
    chk("full_ready",  bus.req_ready,     0);
    chk("hold_start",  bus.loop_ap_start, 1);
    bus.req_valid = 1'b1;
    bus.req_key   = 32'hA6;
    bus.req_len   = 16'd2;
    step();
    chk("full_no_accept", bus.req_ready, 0);
    c_hold = 1'b0;
    fork
      begin
        int n = 0;
        while (!bus.req_ready && n < 300) begin step(); n++; end
        chk("late_accept", bus.req_ready, 1);
        step();
        bus.req_valid = 1'b0;
      end
      begin
        for (int i = 0; i < 6; i++) get_rsp("fifo", 32'hA1 + i, 16'd2, 2'b00, 300);
      end
    join
    chk("fifo_nstarts", start_keys.size(), 6);
    for (int i = 0; i < 6; i++) chk("fifo_order", start_keys[i], 32'hA1 + i);
    wait_child();

    // Zero-length job between two len=3 jobs
    c_iters = 3;
    start_keys.delete();
    s0 = start_cnt;
    push(32'hB1, 16'd3);
    push(32'hB2, 16'd0);
    push(32'hB3, 16'd3);
    get_rsp("mix1", 32'hB1, 16'd3, 2'b00, 100);
    get_rsp("mix2", 32'hB2, 16'd0, 2'b00, 100);
    get_rsp("mix3", 32'hB3, 16'd3, 2'b00, 100);
    chk("mix_starts",  start_cnt - s0, 2);
    chk("mix_order0",  start_keys[0], 32'hB1);
    chk("mix_order1",  start_keys[1], 32'hB3);
    wait_child();

    // Response backpressure with a job waiting behind it
    c_iters = 2;
    push(32'hC1, 16'd2);
    push(32'hC2, 16'd2);
    wait_rsp(100);
    s0 = start_cnt;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp_valid", bus.rsp_valid, 1);
      chk("bp_key",   bus.rsp_key,   32'hC1);
      chk("bp_iters", bus.rsp_iters, 2);
      chk("bp_err",   bus.rsp_err,   0);
    end
    chk("bp_no_start", start_cnt - s0, 0);
    get_rsp("bp1", 32'hC1, 16'd2, 2'b00, 10);
    get_rsp("bp2", 32'hC2, 16'd2, 2'b00, 100);
    wait_child();

    // Timeout: done withheld for 5000 cycles
    c_iters = 1;
    c_extra = 5000;
    push(32'hD1, 16'd1);
    repeat (4200) step();
    chk("tmo_no_rsp", bus.rsp_valid, 0);
    get_rsp("tmo", 32'hD1, 16'd1, 2'b10, 1500);
    wait_child();
    c_extra = 0;

    // Reset in RUN with a second job queued
    c_chk   = 1'b0;
    c_iters = 2;
    c_extra = 30;
    push(32'hE1, 16'd2);
    repeat (5) step();
    push(32'hE2, 16'd2);
    #3;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_start",     bus.loop_ap_start, 0);
    chk("mid_rst_loop_key",  bus.loop_key,      0);
    chk("mid_rst_loop_len",  bus.loop_len,      0);
    chk("mid_rst_rsp_valid", bus.rsp_valid,     0);
    chk("mid_rst_rsp_iters", bus.rsp_iters,     0);
    chk("mid_rst_req_ready", bus.req_ready,     0);
    chk("mid_rst_idle",      bus.idle,          1);
    @(negedge clk);
    rst_n = 1'b1;
    wait_child();
    step();
    chk("post_rst_idle",  bus.idle,      1);
    chk("post_rst_ready", bus.req_ready, 1);
    s0 = start_cnt;
    repeat (3) step();
    chk("post_rst_flushed", start_cnt - s0, 0);
    c_chk   = 1'b1;
    c_extra = 0;
    push(32'hE3, 16'd2);
    get_rsp("post_rst", 32'hE3, 16'd2, 2'b00, 100);
    chk("post_rst_starts", start_cnt - s0, 1);
    wait_child();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
